// File: rtl/cd_drive_link.sv
// cd_drive_link
//   Drive-side responder of the CD mechanism serial link. Each frame shifts
//   FRAME_BYTES status bytes out on CDATA and captures the same number of
//   command bytes from HDATA, full-duplex and LSB first. The drive paces the
//   link: COMSYNC_N marks the frame start, and COMREQ_N requests each byte.
//   The host supplies COMCLK.
//
//   Handshake: START is a one-CLK request and is taken only in IDLE. BUSY
//   stays high from START until the frame completes or aborts. CMD_VALID
//   pulses for one CLK when CMD takes a new complete frame. ABORT pulses for
//   one CLK when the host stops clocking a requested byte.
//
// Ports
//   CLK, RST           system clock, asynchronous active-high reset
//   CE                 clock enable for the lead/gap/timeout counters
//   START, STAT        frame request; STAT is latched on START
//   BUSY               frame in progress
//   CMD, CMD_VALID     last complete command frame, update strobe
//   ABORT              timeout strobe
//   COMCLK, HDATA      host serial clock and data (asynchronous to CLK)
//   CDATA              drive serial data
//   COMREQ_N           byte request, active low
//   COMSYNC_N          frame sync, active low
module cd_drive_link #(
    parameter int FRAME_BYTES = 13,
    parameter int SYNC_LEAD   = 4,
    parameter int BYTE_GAP    = 16,
    parameter int TIMEOUT     = 4096
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CE,
    input  logic                     START,
    input  logic [8*FRAME_BYTES-1:0] STAT,
    output logic                     BUSY,
    output logic [8*FRAME_BYTES-1:0] CMD,
    output logic                     CMD_VALID,
    output logic                     ABORT,
    input  logic                     COMCLK,
    input  logic                     HDATA,
    output logic                     CDATA,
    output logic                     COMREQ_N,
    output logic                     COMSYNC_N
);

    localparam int BYTE_W = $clog2(FRAME_BYTES) + 1;
    localparam int LEAD_W = $clog2(SYNC_LEAD) + 1;
    localparam int GAP_W  = $clog2(BYTE_GAP) + 1;
    localparam int PH_W   = (LEAD_W > GAP_W) ? LEAD_W : GAP_W;
    localparam int TO_W   = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, SYNC, REQ, GAP, DONE} state_t;

    state_t state, state_nxt;

    logic                     comclk_s1, comclk_s2, comclk_q;
    logic                     hdata_s1, hdata_s2;
    logic                     rise;

    logic [8*FRAME_BYTES-1:0] stat_sh;
    logic [8*FRAME_BYTES-1:0] cmd_sh;
    logic [7:0]               rx_byte;
    logic [3:0]               bit_cnt;
    logic [BYTE_W-1:0]        byte_cnt;
    logic [PH_W-1:0]          phase_cnt;   // shared by SYNC lead and GAP
    logic [TO_W-1:0]          to_cnt;

    logic [7:0]               cur_byte;
    logic [7:0]               rx_next;
    logic [2:0]               nxt_bit;
    logic                     enter_req;
    logic                     byte_done;
    logic                     last_byte;
    logic                     to_hit;

    // Synchronizers run every CLK so no COMCLK edge is lost while CE is low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            comclk_s1 <= 1'b0;
            comclk_s2 <= 1'b0;
            comclk_q  <= 1'b0;
            hdata_s1  <= 1'b0;
            hdata_s2  <= 1'b0;
        end else begin
            comclk_s1 <= COMCLK;
            comclk_s2 <= comclk_s1;
            comclk_q  <= comclk_s2;
            hdata_s1  <= HDATA;
            hdata_s2  <= hdata_s1;
        end
    end

    assign rise      = comclk_s2 & ~comclk_q;
    assign cur_byte  = stat_sh[{byte_cnt, 3'b000} +: 8];
    assign rx_next   = {hdata_s2, rx_byte[7:1]};
    assign nxt_bit   = bit_cnt[2:0] + 3'd1;
    assign byte_done = rise && (bit_cnt == 4'd7);
    assign last_byte = (byte_cnt == BYTE_W'(FRAME_BYTES - 1));
    // A rise in the same CLK as the terminal count wins: the host is alive.
    assign to_hit    = !rise && CE && (to_cnt == TO_W'(TIMEOUT - 1));
    assign enter_req = ((state == SYNC) && CE && (phase_cnt == PH_W'(SYNC_LEAD - 1))) ||
                       ((state == GAP)  && CE && (phase_cnt == PH_W'(BYTE_GAP - 1)));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (START) state_nxt = SYNC;
            SYNC: if (enter_req) state_nxt = REQ;
            REQ: begin
                if (byte_done)   state_nxt = last_byte ? DONE : GAP;
                else if (to_hit) state_nxt = IDLE;
            end
            GAP:  if (enter_req) state_nxt = REQ;
            DONE: state_nxt = IDLE;   // START in this cycle is deliberately dropped
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CDATA     <= 1'b1;
            COMREQ_N  <= 1'b1;
            COMSYNC_N <= 1'b1;
            BUSY      <= 1'b0;
            CMD       <= '0;
            CMD_VALID <= 1'b0;
            ABORT     <= 1'b0;
            stat_sh   <= '0;
            cmd_sh    <= '0;
            rx_byte   <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            phase_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            CMD_VALID <= 1'b0;
            ABORT     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        stat_sh   <= STAT;
                        BUSY      <= 1'b1;
                        byte_cnt  <= '0;
                        phase_cnt <= '0;
                        COMSYNC_N <= 1'b0;
                    end
                end
                SYNC, GAP: begin
                    if (CE) phase_cnt <= phase_cnt + PH_W'(1);
                    if (enter_req) begin
                        COMREQ_N <= 1'b0;
                        CDATA    <= cur_byte[0];
                        bit_cnt  <= '0;
                        to_cnt   <= '0;
                    end
                end
                REQ: begin
                    if (rise) begin
                        rx_byte <= rx_next;
                        bit_cnt <= bit_cnt + 4'd1;
                        to_cnt  <= '0;
                        if (byte_done) begin
                            cmd_sh[{byte_cnt, 3'b000} +: 8] <= rx_next;
                            COMREQ_N  <= 1'b1;
                            COMSYNC_N <= 1'b1;   // sync spans only the first byte
                            CDATA     <= 1'b1;
                            byte_cnt  <= byte_cnt + BYTE_W'(1);
                            phase_cnt <= '0;
                        end else begin
                            // Next bit goes out right after the host's rise,
                            // a full half-period ahead of its next sample.
                            CDATA <= cur_byte[nxt_bit];
                        end
                    end else if (to_hit) begin
                        ABORT     <= 1'b1;
                        COMREQ_N  <= 1'b1;
                        COMSYNC_N <= 1'b1;
                        CDATA     <= 1'b1;
                        BUSY      <= 1'b0;
                    end else if (CE) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                DONE: begin
                    CMD       <= cmd_sh;
                    CMD_VALID <= 1'b1;
                    BUSY      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cd_drive_link.sv
// Directed bench for cd_drive_link: a host model clocks COMCLK/HDATA per
// COMREQ_N strobe and collects CDATA; a passive monitor measures lead and
// gap lengths in CE cycles and counts CMD_VALID/ABORT pulses.
module tb_cd_drive_link;

    localparam int FB        = 13;
    localparam int SYNC_LEAD = 4;
    localparam int BYTE_GAP  = 16;
    localparam int TIMEOUT   = 4096;

    logic            clk;
    logic            rst;
    logic            ce;
    logic            start;
    logic [8*FB-1:0] stat;
    logic            busy;
    logic [8*FB-1:0] cmd;
    logic            cmd_valid;
    logic            abort;
    logic            comclk;
    logic            hdata;
    logic            cdata;
    logic            comreq_n;
    logic            comsync_n;

    logic            ce_half = 1'b0;
    int              checks = 0;
    int              errors = 0;

    cd_drive_link #(
        .FRAME_BYTES(FB),
        .SYNC_LEAD  (SYNC_LEAD),
        .BYTE_GAP   (BYTE_GAP),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .CE       (ce),
        .START    (start),
        .STAT     (stat),
        .BUSY     (busy),
        .CMD      (cmd),
        .CMD_VALID(cmd_valid),
        .ABORT    (abort),
        .COMCLK   (comclk),
        .HDATA    (hdata),
        .CDATA    (cdata),
        .COMREQ_N (comreq_n),
        .COMSYNC_N(comsync_n)
    );

    // ---------------- clock / reset / CE ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        ce = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ce = ce_half ? ~ce : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- monitor ----------------
    logic ce_s;
    logic busy_q = 1'b0;
    logic req_q = 1'b1;
    logic lead_pending = 1'b0;
    logic had_rise = 1'b0;
    int   ce_cnt = 0;
    int   start_ce = 0;
    int   rise_ce = 0;
    int   last_lead = -1;
    int   gap_cnt = 0;
    int   gap_bad = 0;
    int   sync_bytes = 0;
    int   sync_bad = 0;
    int   valid_cnt = 0;
    int   abort_cnt = 0;

    always @(posedge clk) begin
        ce_s = ce;
        #1;
        if (ce_s) ce_cnt++;
        if (busy && !busy_q) begin
            start_ce     = ce_cnt;
            lead_pending = 1'b1;
            had_rise     = 1'b0;
        end
        if (!comreq_n && req_q) begin
            if (lead_pending) begin
                last_lead    = ce_cnt - start_ce;
                lead_pending = 1'b0;
            end
            if (had_rise) begin
                gap_cnt++;
                if (ce_cnt - rise_ce != BYTE_GAP) gap_bad++;
            end
            if (!comsync_n) sync_bytes++;
        end
        if (comreq_n && !req_q) begin
            rise_ce  = ce_cnt;
            had_rise = 1'b1;
            if (!comsync_n) sync_bad++;
        end
        if (cmd_valid) valid_cnt++;
        if (abort) abort_cnt++;
        busy_q = busy;
        req_q  = comreq_n;
    end

    // ---------------- helpers ----------------
    int v0, a0, s0, sb0, g0, gb0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*FB-1:0] build(input logic [7:0] base);
        logic [8*FB-1:0] r;
        for (int k = 0; k < FB; k++) r[k*8 +: 8] = 8'(base + k);
        return r;
    endfunction

    task automatic snap();
        v0 = valid_cnt; a0 = abort_cnt; s0 = sync_bytes;
        sb0 = sync_bad; g0 = gap_cnt; gb0 = gap_bad;
    endtask

    task automatic kick(input logic [7:0] sbase);
        stat  = build(sbase);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_req(output logic got);
        got = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (comreq_n === 1'b0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One host bit: present HDATA, raise COMCLK, confirm CDATA holds until
    // the drive has taken the edge, optionally pulse START on the CLK in
    // which the drive is in DONE (after the frame's final rise).
    task automatic host_bit(input logic hb, input logic pulse_start,
                            output logic cb, output logic ok);
        hdata = hb;
        repeat (3) @(negedge clk);
        cb     = cdata;
        comclk = 1'b1;
        @(negedge clk);
        ok = (cdata === cb);
        @(negedge clk);
        ok = ok && (cdata === cb);
        @(negedge clk);
        if (pulse_start) start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        comclk = 1'b0;
    endtask

    task automatic host_byte(input logic [7:0] hb, input int nbits, input logic start_last,
                             output logic [7:0] cb, output logic ok);
        logic b, bok;
        cb = '0;
        ok = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            host_bit(hb[i], start_last && (i == 7), b, bok);
            cb[i] = b;
            ok    = ok && bok;
        end
    endtask

    task automatic stray_pulse();
        comclk = 1'b1;
        repeat (4) @(negedge clk);
        comclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic host_frame(input logic [7:0] sbase, input logic [7:0] hbase,
                              input int last_idx, input int last_bits,
                              input logic stray_gap, input logic mid_start,
                              input logic start_on_done);
        logic [7:0] cb;
        logic       ok, got;
        int         nb;
        for (int k = 0; k <= last_idx; k++) begin
            if (mid_start && k == 3) begin
                stat  = {FB{8'hFF}};
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_req(got);
            chk("req_wait", 128'(got), 128'd1);
            if (!got) return;
            nb = (k == last_idx) ? last_bits : 8;
            host_byte(8'(hbase + k), nb, start_on_done && (k == FB - 1), cb, ok);
            if (nb == 8) begin
                chk("cdata_byte", 128'(cb), 128'(8'(sbase + k)));
                chk("cdata_stable", 128'(ok), 128'd1);
            end
            if (stray_gap && k == 1) stray_pulse();
        end
    endtask

    task automatic check_frame(input logic [7:0] hbase, input string tag);
        repeat (4) @(negedge clk);
        chk({tag, "_cmd"}, 128'(cmd), 128'(build(hbase)));
        chk({tag, "_valid_cnt"}, 128'(valid_cnt - v0), 128'd1);
        chk({tag, "_abort_cnt"}, 128'(abort_cnt - a0), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_sync_bytes"}, 128'(sync_bytes - s0), 128'd1);
        chk({tag, "_sync_late"}, 128'(sync_bad - sb0), 128'd0);
        chk({tag, "_gap_count"}, 128'(gap_cnt - g0), 128'(FB - 1));
        chk({tag, "_gap_len"}, 128'(gap_bad - gb0), 128'd0);
        chk({tag, "_sync_lead"}, 128'(last_lead), 128'(SYNC_LEAD));
    endtask

    // ---------------- directed sequence ----------------
    logic       got, ok;
    logic [7:0] cb;
    int         found;

    initial begin
        rst = 1'b1; start = 1'b0; stat = '0; comclk = 1'b0; hdata = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_cdata", 128'(cdata), 128'd1);
        chk("rst_comreq_n", 128'(comreq_n), 128'd1);
        chk("rst_comsync_n", 128'(comsync_n), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_cmd", 128'(cmd), 128'd0);
        chk("rst_cmd_valid", 128'(cmd_valid), 128'd0);
        chk("rst_abort", 128'(abort), 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame A: full frame, CE always high.
        snap();
        kick(8'h10);
        chk("a_busy", 128'(busy), 128'd1);
        host_frame(8'h10, 8'hA0, FB - 1, 8, 1'b0, 1'b0, 1'b0);
        check_frame(8'hA0, "a");

        // Stray COMCLK while idle changes nothing.
        stray_pulse();
        repeat (4) @(negedge clk);
        chk("idle_stray_cmd", 128'(cmd), 128'(build(8'hA0)));
        chk("idle_stray_busy", 128'(busy), 128'd0);

        // Frame B: CE at half rate, STAT changed and START pulsed mid-frame,
        // stray COMCLK in a gap.
        ce_half = 1'b1;
        snap();
        kick(8'h30);
        host_frame(8'h30, 8'h50, FB - 1, 8, 1'b1, 1'b1, 1'b0);
        check_frame(8'h50, "b");
        repeat (40) @(negedge clk);
        chk("b_no_second_busy", 128'(busy), 128'd0);
        chk("b_no_second_valid", 128'(valid_cnt - v0), 128'd1);
        ce_half = 1'b0;
        repeat (4) @(negedge clk);

        // Frame C: host stops after 3 bits of byte 5.
        snap();
        kick(8'h20);
        host_frame(8'h20, 8'hB0, 4, 8, 1'b0, 1'b0, 1'b0);
        wait_req(got);
        chk("c_req5", 128'(got), 128'd1);
        host_byte(8'hB5, 2, 1'b0, cb, ok);
        hdata = 1'b1;
        repeat (3) @(negedge clk);
        comclk = 1'b1;
        found  = 0;
        for (int n = 1; n <= TIMEOUT + 20; n++) begin
            @(negedge clk);
            if (n == 4) comclk = 1'b0;
            if (abort === 1'b1) begin
                found = n;
                break;
            end
        end
        // Three CLKs of synchronizer/edge-detect latency precede the counted rise.
        chk("c_abort_latency", 128'(found), 128'(TIMEOUT + 3));
        @(negedge clk);
        chk("c_abort_width", 128'(abort), 128'd0);
        chk("c_abort_cnt", 128'(abort_cnt - a0), 128'd1);
        chk("c_cmd_kept", 128'(cmd), 128'(build(8'h50)));
        chk("c_no_valid", 128'(valid_cnt - v0), 128'd0);
        chk("c_comreq_n", 128'(comreq_n), 128'd1);
        chk("c_comsync_n", 128'(comsync_n), 128'd1);
        chk("c_cdata", 128'(cdata), 128'd1);
        chk("c_busy", 128'(busy), 128'd0);
        repeat (4) @(negedge clk);

        // Frame D: reset asserted during byte 7.
        snap();
        kick(8'h70);
        host_frame(8'h70, 8'h90, 7, 4, 1'b0, 1'b0, 1'b0);
        chk("d_req_low_before_rst", 128'(comreq_n), 128'd0);
        #2 rst = 1'b1;
        #1;
        chk("d_rst_comreq_n", 128'(comreq_n), 128'd1);
        chk("d_rst_comsync_n", 128'(comsync_n), 128'd1);
        chk("d_rst_cdata", 128'(cdata), 128'd1);
        chk("d_rst_busy", 128'(busy), 128'd0);
        chk("d_rst_cmd", 128'(cmd), 128'd0);
        chk("d_rst_valid", 128'(cmd_valid), 128'd0);
        chk("d_rst_abort", 128'(abort), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("d_no_valid", 128'(valid_cnt - v0), 128'd0);

        // Frame E: clean frame after reset, START pulsed in the DONE cycle.
        snap();
        kick(8'h60);
        host_frame(8'h60, 8'hC0, FB - 1, 8, 1'b0, 1'b0, 1'b1);
        check_frame(8'hC0, "e");
        repeat (10) @(negedge clk);
        chk("e_done_start_ignored", 128'(busy), 128'd0);
        chk("e_single_valid", 128'(valid_cnt - v0), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
